// File: rtl/score_keeper.sv
// Foosball goal detector and score counter: credits goals, holds the goal request
// until the controller acknowledges it, and issues one double-ball request per match.
module score_keeper #(
    parameter int MAX_SCORE   = 9,
    parameter int DOUBLE_AT   = 4,
    parameter int LEFT_LINE   = 16,
    parameter int RIGHT_LINE  = 623,
    parameter int GOAL_TOP    = 180,
    parameter int GOAL_BOTTOM = 300
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic [10:0] ball_x,
    input  logic [10:0] ball_y,
    input  logic        move,
    input  logic        idle,
    input  logic        goal_ena,
    input  logic        double_ball_ena,
    output logic        goal,
    output logic        Max_goal,
    output logic        double_ball,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        last_scorer
);

    localparam logic [3:0]  MAX_S  = 4'(MAX_SCORE);
    localparam logic [4:0]  DB_AT  = 5'(DOUBLE_AT);
    localparam logic [10:0] LEFT_L = 11'(LEFT_LINE);
    localparam logic [10:0] RIGHT_L = 11'(RIGHT_LINE);
    localparam logic [10:0] TOP_Y  = 11'(GOAL_TOP);
    localparam logic [10:0] BOT_Y  = 11'(GOAL_BOTTOM);

    typedef enum logic [1:0] {WAIT, PLAY, PEND, HOLD} state_t;

    state_t     state;
    logic [4:0] total;
    logic       armed;
    logic       db_pending;
    logic       db_used;

    logic       in_mouth;
    logic       left_hit;
    logic       right_hit;
    logic       goal_hit;
    logic [4:0] total_next;

    function automatic logic [3:0] inc_sat(input logic [3:0] s);
        return (s < MAX_S) ? s + 4'd1 : s;
    endfunction

    always_comb begin
        in_mouth   = (ball_y >= TOP_Y) && (ball_y <= BOT_Y);
        left_hit   = in_mouth && (ball_x <= LEFT_L);
        // Left zone wins if both zones overlap through misconfigured lines.
        right_hit  = in_mouth && !left_hit && (ball_x >= RIGHT_L);
        goal_hit   = (state == PLAY) && startOfFrame && armed && (left_hit || right_hit);
        total_next = (total == 5'd31) ? total : total + 5'd1;
    end

    assign Max_goal    = (score_left == MAX_S) || (score_right == MAX_S);
    assign double_ball = db_pending && (state == PLAY) && move;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= WAIT;
            total       <= '0;
            armed       <= 1'b0;
            db_pending  <= 1'b0;
            db_used     <= 1'b0;
            goal        <= 1'b0;
            score_left  <= '0;
            score_right <= '0;
            last_scorer <= 1'b0;
        end else if (idle) begin
            state       <= WAIT;
            total       <= '0;
            armed       <= 1'b0;
            db_pending  <= 1'b0;
            db_used     <= 1'b0;
            goal        <= 1'b0;
            score_left  <= '0;
            score_right <= '0;
            last_scorer <= 1'b0;
        end else begin
            if (startOfFrame && !left_hit && !right_hit)
                armed <= 1'b1;

            case (state)
                WAIT: if (move) state <= PLAY;
                PLAY: begin
                    if (goal_hit) begin
                        if (left_hit) begin
                            score_right <= inc_sat(score_right);
                            last_scorer <= 1'b1;
                        end else begin
                            score_left  <= inc_sat(score_left);
                            last_scorer <= 1'b0;
                        end
                        total <= total_next;
                        armed <= 1'b0;
                        goal  <= 1'b1;
                        state <= PEND;
                        if (!db_used && (total_next == DB_AT) && (total != DB_AT))
                            db_pending <= 1'b1;
                    end else if (!move) begin
                        state <= WAIT;
                    end
                end
                PEND: begin
                    if (goal_ena) begin
                        goal  <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (move)
                        state <= PLAY;
                    else if (!goal_ena)
                        state <= WAIT;
                end
                default: state <= WAIT;
            endcase

            if (double_ball_ena) begin
                db_pending <= 1'b0;
                db_used    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with default parameters.
module tb_score_keeper;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] ball_x = '0;
    logic [10:0] ball_y = '0;
    logic        move = 1'b0;
    logic        idle = 1'b0;
    logic        goal_ena = 1'b0;
    logic        double_ball_ena = 1'b0;
    logic        goal;
    logic        Max_goal;
    logic        double_ball;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        last_scorer;

    int checks = 0;
    int errors = 0;

    score_keeper #(
        .MAX_SCORE(9), .DOUBLE_AT(4), .LEFT_LINE(16),
        .RIGHT_LINE(623), .GOAL_TOP(180), .GOAL_BOTTOM(300)
    ) dut (
        .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame),
        .ball_x(ball_x), .ball_y(ball_y), .move(move), .idle(idle),
        .goal_ena(goal_ena), .double_ball_ena(double_ball_ena),
        .goal(goal), .Max_goal(Max_goal), .double_ball(double_ball),
        .score_left(score_left), .score_right(score_right), .last_scorer(last_scorer)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic frame(input int x, input int y);
        ball_x = 11'(x);
        ball_y = 11'(y);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    // Arm with a neutral frame, then present the ball at (x,y).
    task automatic score_at(input int x, input int y);
        frame(300, 200);
        frame(x, y);
    endtask

    task automatic ack_goal();
        goal_ena = 1'b1;
        tick();
        goal_ena = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESETn = 1'b1;
        #2 RESETn = 1'b0;
        #1;
        checks++;
        if ({goal, Max_goal, double_ball, score_left, score_right, last_scorer} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                {goal, Max_goal, double_ball, score_left, score_right, last_scorer});
        end
        tick();
        tick();
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_first_goal();
        move = 1'b1;
        tick();
        frame(300, 200);
        frame(8, 200);
        checks++;
        if (goal !== 1'b1) begin errors++; $display("FAIL first_goal got %b want 1", goal); end
        checks++;
        if (score_right !== 4'd1) begin errors++; $display("FAIL first_score_right got %0d want 1", score_right); end
        checks++;
        if (last_scorer !== 1'b1) begin errors++; $display("FAIL first_last_scorer got %b want 1", last_scorer); end
        goal_ena = 1'b1;
        tick();
        checks++;
        if (goal !== 1'b0) begin errors++; $display("FAIL goal_ack_drop got %b want 0", goal); end
        goal_ena = 1'b0;
        tick();
    endtask

    task automatic test_rearm();
        for (int i = 0; i < 3; i++) frame(8, 200);
        checks++;
        if (goal !== 1'b0 || score_right !== 4'd1) begin
            errors++;
            $display("FAIL no_rearm got goal=%b score_right=%0d want goal=0 score_right=1", goal, score_right);
        end
        score_at(8, 200);
        checks++;
        if (goal !== 1'b1 || score_right !== 4'd2) begin
            errors++;
            $display("FAIL rearm_goal got goal=%b score_right=%0d want goal=1 score_right=2", goal, score_right);
        end
        ack_goal();
    endtask

    task automatic test_mouth();
        frame(300, 200);
        frame(630, 100);
        checks++;
        if (goal !== 1'b0 || score_left !== 4'd0) begin
            errors++;
            $display("FAIL outside_mouth got goal=%b score_left=%0d want goal=0 score_left=0", goal, score_left);
        end
        frame(630, 180);
        checks++;
        if (goal !== 1'b1 || score_left !== 4'd1 || last_scorer !== 1'b0) begin
            errors++;
            $display("FAIL top_row_goal got goal=%b score_left=%0d last=%b want 1 1 0", goal, score_left, last_scorer);
        end
        ack_goal();
    endtask

    task automatic test_double_ball();
        score_at(630, 250);
        checks++;
        if (score_left !== 4'd2 || double_ball !== 1'b0) begin
            errors++;
            $display("FAIL db_in_pend got score_left=%0d double_ball=%b want 2 0", score_left, double_ball);
        end
        ack_goal();
        checks++;
        if (double_ball !== 1'b1) begin errors++; $display("FAIL db_request got %b want 1", double_ball); end
        double_ball_ena = 1'b1;
        tick();
        double_ball_ena = 1'b0;
        checks++;
        if (double_ball !== 1'b0) begin errors++; $display("FAIL db_ack got %b want 0", double_ball); end
        for (int g = 0; g < 4; g++) begin
            score_at(630, 250);
            ack_goal();
            checks++;
            if (double_ball !== 1'b0) begin
                errors++;
                $display("FAIL db_repeat goal %0d got %b want 0", g + 5, double_ball);
            end
        end
        checks++;
        if (score_left !== 4'd6) begin errors++; $display("FAIL db_left_total got %0d want 6", score_left); end
    endtask

    task automatic test_saturation();
        for (int g = 0; g < 2; g++) begin
            score_at(630, 250);
            ack_goal();
        end
        checks++;
        if (score_left !== 4'd8 || Max_goal !== 1'b0) begin
            errors++;
            $display("FAIL sat_at_8 got score_left=%0d Max_goal=%b want 8 0", score_left, Max_goal);
        end
        score_at(630, 300);
        checks++;
        if (score_left !== 4'd9 || Max_goal !== 1'b1 || goal !== 1'b1) begin
            errors++;
            $display("FAIL sat_win got score_left=%0d Max_goal=%b goal=%b want 9 1 1", score_left, Max_goal, goal);
        end
        ack_goal();
        score_at(630, 250);
        checks++;
        if (score_left !== 4'd9 || Max_goal !== 1'b1 || goal !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got score_left=%0d Max_goal=%b goal=%b want 9 1 1", score_left, Max_goal, goal);
        end
    endtask

    task automatic test_idle();
        idle = 1'b1;
        tick();
        idle = 1'b0;
        checks++;
        if ({goal, Max_goal, double_ball, score_left, score_right, last_scorer} !== 15'd0) begin
            errors++;
            $display("FAIL idle_clear got %b want 0",
                {goal, Max_goal, double_ball, score_left, score_right, last_scorer});
        end
    endtask

    task automatic test_async_reset();
        move = 1'b1;
        tick();
        score_at(8, 220);
        checks++;
        if (goal !== 1'b1 || score_right !== 4'd1) begin
            errors++;
            $display("FAIL post_idle_goal got goal=%b score_right=%0d want 1 1", goal, score_right);
        end
        ack_goal();
        #2 RESETn = 1'b0;
        #1;
        checks++;
        if ({goal, score_left, score_right, last_scorer} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got %b want 0", {goal, score_left, score_right, last_scorer});
        end
        tick();
        RESETn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_goal();
        test_rearm();
        test_mouth();
        test_double_ball();
        test_saturation();
        test_idle();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
